// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic block: divider FSM states and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package arith_pkg;

  // Divider controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Width of an iteration counter able to hold 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider32_div_step.sv
// One restoring shift-subtract iteration of the divider, purely combinational.
// Latency: 0 cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   i_partial_rem  current partial remainder (always < divisor)
//   i_dividend_msb next dividend bit shifted into the remainder
//   i_divisor      divisor magnitude
//   o_partial_rem  partial remainder after this step
//   o_q_bit        quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_partial_rem,
  input  logic             i_dividend_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_partial_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  always_comb begin
    // The shifted remainder needs WIDTH+1 bits: the old remainder may have
    // its MSB set when the divisor is large. The difference always fits in
    // WIDTH+1 signed bits, so its top bit is the borrow/sign.
    w_shifted     = {i_partial_rem, i_dividend_msb};
    w_diff        = w_shifted - {1'b0, i_divisor};
    o_q_bit       = ~w_diff[WIDTH];
    o_partial_rem = o_q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle signed/unsigned integer divider (restoring, one quotient bit per clock).
// Latency: done pulses WIDTH+2 edges after the start edge (2 edges on divide-by-zero).
// Backpressure: start is only sampled while idle; starts during busy are dropped.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start               request, sampled only in idle
//   i_is_signed           1 = two's-complement operands (sampled with start)
//   i_dividend, i_divisor operands (sampled with start)
//   o_busy                high while a division is in progress
//   o_done                one-cycle pulse, results valid from this cycle on
//   o_quotient            quotient truncated toward zero
//   o_remainder           remainder with the sign of the dividend
//   o_div_by_zero         set with done when divisor was zero
module seq_divider32
  import arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;        // partial remainder
  logic [WIDTH-1:0] r_dq;         // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_dvs;        // divisor magnitude
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dz;
  logic             r_done;

  logic [WIDTH-1:0] w_dividend_abs;
  logic [WIDTH-1:0] w_divisor_abs;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_q_bit;
  logic             w_last;

  assign w_dividend_abs = (i_is_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
  assign w_divisor_abs  = (i_is_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;
  assign w_last         = (r_cnt == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_partial_rem  (r_rem),
    .i_dividend_msb (r_dq[WIDTH-1]),
    .i_divisor      (r_dvs),
    .o_partial_rem  (w_step_rem),
    .o_q_bit        (w_q_bit)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = (i_divisor == '0) ? ST_FIX : ST_CALC;
      ST_CALC: if (w_last)  w_state_nxt = ST_FIX;
      ST_FIX:               w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dq        <= '0;
      r_dvs       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dz        <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_dq    <= w_dividend_abs;
            r_dvs   <= w_divisor_abs;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_q <= i_is_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
            r_neg_r <= i_is_signed & i_dividend[WIDTH-1];
            r_dz    <= 1'b0;
          end
        end
        ST_CALC: begin
          r_rem <= w_step_rem;
          r_dq  <= {r_dq[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          r_done <= 1'b1;
          if (r_dvs == '0) begin
            // No iterations ran, so r_dq still holds |dividend|; re-applying
            // the dividend sign recovers the raw dividend.
            r_quotient  <= '1;
            r_remainder <= r_neg_r ? -r_dq : r_dq;
            r_dz        <= 1'b1;
          end else begin
            r_quotient  <= r_neg_q ? -r_dq  : r_dq;
            r_remainder <= r_neg_r ? -r_rem : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider32.sv
module tb_seq_divider32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dz;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_divider32 #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_is_signed   (is_signed),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dz)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    longint sa, sb, tq, tr;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[W-1:0];
      r  = tr[W-1:0];
      z  = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Transaction-level model: a division accepted while idle completes a
  // fixed number of edges later; results are held until the next completion.
  int           m_left = 0;
  logic [W-1:0] p_q, p_r;
  logic         p_z;
  logic         e_busy = 0, e_done = 0, e_z = 0;
  logic [W-1:0] e_q = '0, e_r = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; e_busy = 0; e_done = 0; e_q = '0; e_r = '0; e_z = 0;
    end else begin
      e_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          e_q = p_q; e_r = p_r; e_z = p_z; e_done = 1'b1;
        end
      end else if (start) begin
        ref_div(is_signed, dividend, divisor, p_q, p_r, p_z);
        e_z    = 1'b0;
        m_left = p_z ? 1 : W + 1;
      end
      e_busy = (m_left > 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("quotient", quotient, e_q);
      chk("remainder", remainder, e_r);
      chk("div_by_zero", {31'd0, dz}, {31'd0, e_z});
    end
  end

  task automatic do_start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #2;
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Called just after the start edge; returns edges from e0 to the edge
  // that raised done, and the number of busy cycles observed.
  task automatic wait_done(input string nm, output int edges, output int bcnt);
    bit got;
    got   = 1'b0;
    edges = 0;
    bcnt  = busy ? 1 : 0;
    while (!got && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (done) got = 1'b1;
      else if (busy) bcnt++;
    end
    chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, bcnt, seen;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #2 chk_en = 1'b1;
    rst_n = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);

    // Unsigned reference case with latency and busy length.
    do_start(1'b0, 32'd14093195, 32'd2955);
    wait_done("unsigned", edges, bcnt);
    chk("unsigned_q", quotient, 32'd4769);
    chk("unsigned_r", remainder, 32'd800);
    chk("unsigned_dz", {31'd0, dz}, 32'd0);
    chk("latency_edges_incl_e0", edges + 1, 32'd34);
    chk("busy_cycles", bcnt, 32'd33);

    // Signed negative dividend.
    do_start(1'b1, 32'hFF28F475, 32'd2955);
    wait_done("signed", edges, bcnt);
    chk("signed_q", quotient, 32'hFFFFED5F);
    chk("signed_r", remainder, 32'hFFFFFCE0);

    // Divide by zero.
    do_start(1'b0, 32'd7, 32'd0);
    wait_done("divzero", edges, bcnt);
    chk("divzero_latency", edges, 32'd1);
    chk("divzero_q", quotient, 32'hFFFFFFFF);
    chk("divzero_r", remainder, 32'd7);
    chk("divzero_flag", {31'd0, dz}, 32'd1);

    // Next start clears the flag immediately.
    do_start(1'b0, 32'd100, 32'd7);
    chk("dz_cleared_on_start", {31'd0, dz}, 32'd0);
    wait_done("after_dz", edges, bcnt);
    chk("after_dz_q", quotient, 32'd14);
    chk("after_dz_r", remainder, 32'd2);

    // Signed overflow and unsigned extreme.
    do_start(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done("overflow", edges, bcnt);
    chk("overflow_q", quotient, 32'h80000000);
    chk("overflow_r", remainder, 32'd0);
    chk("overflow_dz", {31'd0, dz}, 32'd0);
    do_start(1'b0, 32'hFFFFFFFF, 32'd1);
    wait_done("umax", edges, bcnt);
    chk("umax_q", quotient, 32'hFFFFFFFF);
    chk("umax_r", remainder, 32'd0);

    // Second start at e0+5 must be ignored.
    do_start(1'b0, 32'd1000, 32'd10);
    repeat (4) @(posedge clk);
    #2 start = 1'b1; dividend = 32'd5; divisor = 32'd5;
    @(posedge clk); #2 start = 1'b0;
    wait_done("ignored", edges, bcnt);
    chk("ignored_q", quotient, 32'd100);
    chk("ignored_r", remainder, 32'd0);

    // Start during the done cycle is accepted.
    #1 start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd3;
    @(posedge clk); #2 start = 1'b0;
    chk("done_cycle_start_busy", {31'd0, busy}, 32'd1);
    wait_done("done_cycle", edges, bcnt);
    chk("done_cycle_q", quotient, 32'd16);
    chk("done_cycle_r", remainder, 32'd2);

    // Reset at e0+10 aborts.
    do_start(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("no_done_after_abort", seen, 32'd0);

    // Fresh signed start after the abort.
    do_start(1'b1, -32'sd100, 32'd7);
    wait_done("post_reset", edges, bcnt);
    chk("post_reset_q", quotient, 32'hFFFFFFF2);
    chk("post_reset_r", remainder, 32'hFFFFFFFE);
    chk("post_reset_latency", edges + 1, 32'd34);

    repeat (3) @(posedge clk);
    #2 chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
